// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, constants and helpers for the manager and its address generator.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      BURST_SINGLE = 3'd0,
      BURST_INCR   = 3'd1,
      BURST_WRAP4  = 3'd2,
      BURST_INCR4  = 3'd3,
      BURST_WRAP8  = 3'd4,
      BURST_INCR8  = 3'd5,
      BURST_WRAP16 = 3'd6,
      BURST_INCR16 = 3'd7
   } hburst_t;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   // Manager sequencing states; encoding is visible on the fsm_state debug port.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_BURST = 3'd2,
      ST_LAST  = 3'd3,
      ST_ERR   = 3'd4
   } master_state_t;

   // Low address bits that must be zero for a transfer of the given size.
   function automatic logic [2:0] size_mask(input logic [2:0] size);
      case (size)
         HSIZE_BYTE: return 3'b000;
         HSIZE_HALF: return 3'b001;
         default:    return 3'b011;
      endcase
   endfunction

   // Number of beats in a burst; len is beats-1 and only matters for INCR.
   function automatic logic [8:0] beat_count(input logic [2:0] burst, input logic [7:0] len);
      case (burst)
         BURST_SINGLE:             return 9'd1;
         BURST_INCR:               return {1'b0, len} + 9'd1;
         BURST_WRAP4, BURST_INCR4: return 9'd4;
         BURST_WRAP8, BURST_INCR8: return 9'd8;
         default:                  return 9'd16;
      endcase
   endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next-beat address for AHB bursts: linear increment, or wrap within a beats*size window.
// Also flags when a linear increment steps into a new 1KB page.
module ahb_addr_gen
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [2:0]        burst,
   output logic [ADDR_W-1:0] next_addr,
   output logic              cross_1k
);

   logic [ADDR_W-1:0] incr;
   logic [ADDR_W-1:0] sum;
   logic [ADDR_W-1:0] wrap_mask;
   logic              is_wrap;

   // Compute incremented address, then splice in the wrap window for WRAP bursts.
   always_comb begin
      incr      = ADDR_W'(1) << size;
      sum       = addr + incr;
      is_wrap   = 1'b1;
      wrap_mask = '0;
      case (burst)
         BURST_WRAP4:  wrap_mask = (ADDR_W'(4) << size) - ADDR_W'(1);
         BURST_WRAP8:  wrap_mask = (ADDR_W'(8) << size) - ADDR_W'(1);
         BURST_WRAP16: wrap_mask = (ADDR_W'(16) << size) - ADDR_W'(1);
         default:      is_wrap = 1'b0;
      endcase
      if (is_wrap) begin
         next_addr = (addr & ~wrap_mask) | (sum & wrap_mask);
         cross_1k  = 1'b0;
      end else begin
         next_addr = sum;
         cross_1k  = (sum[ADDR_W-1:10] != addr[ADDR_W-1:10]);
      end
   end

endmodule

// File: rtl/ahb_master.sv
// AHB-Lite manager: takes one command at a time, runs the pipelined address/data
// phases of the burst, and reports read beats and completion to the local side.
// Local handshake: a command transfers on a cycle where cmd_valid and cmd_ready are
// both high; cmd_ready is high only while idle, so requests made while busy wait.
module ahb_master
   import ahb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_burst,
   input  logic [2:0]        cmd_size,
   input  logic [7:0]        cmd_len,
   input  logic [DATA_W-1:0] wdata,
   output logic              wdata_pop,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              done,
   output logic              done_err,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [3:0]        hprot,
   output logic              hmastlock,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp,
   output logic [2:0]        fsm_state
);

   master_state_t     state, next_state;
   htrans_t           trans;
   logic [8:0]        beats_left;   // address phases still to issue after the current one
   logic              page_cross;   // current beat opens a new 1KB page
   logic [ADDR_W-1:0] next_addr;
   logic              cross_1k;
   logic [ADDR_W-1:0] start_addr;
   logic [2:0]        start_size;
   logic              cmd_fire;
   logic              addr_accept;
   logic              data_phase;
   logic              data_ok;
   logic              data_err;

   assign hprot     = HPROT_DEFAULT;
   assign hmastlock = 1'b0;
   assign fsm_state = state;
   assign htrans    = trans;

   assign start_size  = (cmd_size > HSIZE_WORD) ? HSIZE_WORD : cmd_size;
   assign start_addr  = cmd_addr & ~ADDR_W'(size_mask(start_size));
   assign cmd_fire    = cmd_valid & cmd_ready;
   assign addr_accept = ((state == ST_ADDR) || (state == ST_BURST)) && hready;
   assign data_phase  = (state == ST_BURST) || (state == ST_LAST);
   assign data_ok     = data_phase && hready && !hresp;
   assign data_err    = data_phase && !hready && hresp;

   ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .addr      (haddr),
      .size      (hsize),
      .burst     (hburst),
      .next_addr (next_addr),
      .cross_1k  (cross_1k)
   );

   // State register.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state <= ST_IDLE;
      else          state <= next_state;
   end

   // Next-state: advance on accepted address phases, divert to ERR on the first error cycle.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (cmd_fire) next_state = ST_ADDR;
         ST_ADDR:  if (hready) next_state = (beats_left == 9'd0) ? ST_LAST : ST_BURST;
         ST_BURST: begin
            if (data_err)    next_state = ST_ERR;
            else if (hready) next_state = (beats_left == 9'd0) ? ST_LAST : ST_BURST;
         end
         ST_LAST: begin
            if (data_err)    next_state = ST_ERR;
            else if (hready) next_state = ST_IDLE;
         end
         ST_ERR:   if (hready) next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // State-decoded outputs: transfer type, idle handshake, write-data pop.
   always_comb begin
      trans     = HTRANS_IDLE;
      cmd_ready = 1'b0;
      case (state)
         ST_IDLE:  cmd_ready = 1'b1;
         ST_ADDR:  trans = HTRANS_NONSEQ;
         ST_BURST: trans = page_cross ? HTRANS_NONSEQ : HTRANS_SEQ;
         default:  ;
      endcase
      wdata_pop = addr_accept && hwrite;
   end

   // Address/control registers: load on command accept, step on each accepted address phase.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         haddr      <= '0;
         hwrite     <= 1'b0;
         hsize      <= HSIZE_BYTE;
         hburst     <= BURST_SINGLE;
         beats_left <= '0;
         page_cross <= 1'b0;
      end else if (cmd_fire) begin
         haddr      <= start_addr;
         hwrite     <= cmd_write;
         hsize      <= start_size;
         hburst     <= cmd_burst;
         beats_left <= beat_count(cmd_burst, cmd_len) - 9'd1;
         page_cross <= 1'b0;
      end else if (addr_accept && (beats_left != 9'd0)) begin
         haddr      <= next_addr;
         beats_left <= beats_left - 9'd1;
         page_cross <= cross_1k;
      end
   end

   // Data path: capture write data on address accept, return read data and completion pulses.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         hwdata      <= '0;
         rdata       <= '0;
         rdata_valid <= 1'b0;
         done        <= 1'b0;
         done_err    <= 1'b0;
      end else begin
         if (addr_accept && hwrite) hwdata <= wdata;
         rdata_valid <= data_ok && !hwrite;
         if (data_ok && !hwrite) rdata <= hrdata;
         done     <= ((state == ST_LAST) || (state == ST_ERR)) && hready;
         done_err <= ((state == ST_LAST) && hready && hresp) || ((state == ST_ERR) && hready);
      end
   end

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: single, INCR4, WRAP4, 1KB-crossing INCR, stalled INCR8,
// ERROR termination and mid-burst reset, each with hand-computed expectations.
module tb_ahb_master;

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_burst;
   logic [2:0]  cmd_size;
   logic [7:0]  cmd_len;
   logic [31:0] wdata;
   logic        wdata_pop;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        done;
   logic        done_err;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;
   logic [2:0]  fsm_state;

   int checks   = 0;
   int failures = 0;
   int pop_cnt  = 0;
   int rv_cnt   = 0;
   int done_cnt = 0;
   int base;

   logic [31:0] wrap_addr [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
   logic [31:0] cross_addr[4] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
   logic [1:0]  cross_tr  [4] = '{2'b10, 2'b11, 2'b10, 2'b11};

   ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .hclk        (hclk),
      .hresetn     (hresetn),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_burst   (cmd_burst),
      .cmd_size    (cmd_size),
      .cmd_len     (cmd_len),
      .wdata       (wdata),
      .wdata_pop   (wdata_pop),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .done        (done),
      .done_err    (done_err),
      .haddr       (haddr),
      .htrans      (htrans),
      .hwrite      (hwrite),
      .hsize       (hsize),
      .hburst      (hburst),
      .hprot       (hprot),
      .hmastlock   (hmastlock),
      .hwdata      (hwdata),
      .hrdata      (hrdata),
      .hready      (hready),
      .hresp       (hresp),
      .fsm_state   (fsm_state)
   );

   // Clock generation.
   always #5 hclk = ~hclk;

   // Pulse counters sampled mid-cycle.
   always @(negedge hclk) begin
      if (wdata_pop)   pop_cnt++;
      if (rdata_valid) rv_cnt++;
      if (done)        done_cnt++;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic wr, input logic [31:0] a, input logic [2:0] b, input logic [7:0] l);
      int n = 0;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_burst = b;
      cmd_size  = 3'b010;
      cmd_len   = l;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 20) begin
         tick();
         n++;
      end
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_htrans"}, 32'(htrans), 32'd0);
      chk({tag, "_haddr"}, haddr, 32'd0);
      chk({tag, "_hwrite"}, 32'(hwrite), 32'd0);
      chk({tag, "_hsize"}, 32'(hsize), 32'd0);
      chk({tag, "_hburst"}, 32'(hburst), 32'd0);
      chk({tag, "_hwdata"}, hwdata, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
      chk({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_done_err"}, 32'(done_err), 32'd0);
      chk({tag, "_wdata_pop"}, 32'(wdata_pop), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({tag, "_fsm_state"}, 32'(fsm_state), 32'd0);
   endtask

   initial begin
      hresetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_burst = '0;
      cmd_size  = '0;
      cmd_len   = '0;
      wdata     = '0;
      hrdata    = '0;
      hready    = 1'b1;
      hresp     = 1'b0;
      tick();
      tick();
      chk_reset_outputs("rst");
      chk("hprot", 32'(hprot), 32'h3);
      chk("hmastlock", 32'(hmastlock), 32'd0);
      hresetn = 1'b1;
      tick();

      // Single write @0x10.
      wdata = 32'hDEADBEEF;
      base  = pop_cnt;
      issue(1'b1, 32'h10, 3'b000, 8'd0);
      chk("s_htrans", 32'(htrans), 32'h2);
      chk("s_haddr", haddr, 32'h10);
      chk("s_hwrite", 32'(hwrite), 32'd1);
      chk("s_hsize", 32'(hsize), 32'd2);
      chk("s_hburst", 32'(hburst), 32'd0);
      chk("s_pop", 32'(wdata_pop), 32'd1);
      chk("s_busy", 32'(cmd_ready), 32'd0);
      tick();
      chk("s_last_htrans", 32'(htrans), 32'h0);
      chk("s_hwdata", hwdata, 32'hDEADBEEF);
      chk("s_pop_off", 32'(wdata_pop), 32'd0);
      chk("s_done_early", 32'(done), 32'd0);
      tick();
      chk("s_done", 32'(done), 32'd1);
      chk("s_done_err", 32'(done_err), 32'd0);
      chk("s_ready_back", 32'(cmd_ready), 32'd1);
      chk("s_pops", 32'(pop_cnt - base), 32'd1);
      tick();
      chk("s_done_pulse", 32'(done), 32'd0);

      // INCR4 read @0x20, zero waits.
      base = rv_cnt;
      issue(1'b0, 32'h20, 3'b011, 8'd0);
      chk("r4_haddr0", haddr, 32'h20);
      chk("r4_htrans0", 32'(htrans), 32'h2);
      chk("r4_hburst", 32'(hburst), 32'h3);
      tick();
      chk("r4_haddr1", haddr, 32'h24);
      chk("r4_htrans1", 32'(htrans), 32'h3);
      chk("r4_rv_none", 32'(rdata_valid), 32'd0);
      hrdata = 32'hA0A0_0000;
      tick();
      chk("r4_haddr2", haddr, 32'h28);
      chk("r4_htrans2", 32'(htrans), 32'h3);
      chk("r4_rv0", 32'(rdata_valid), 32'd1);
      chk("r4_rdata0", rdata, 32'hA0A0_0000);
      hrdata = 32'hA0A0_0001;
      tick();
      chk("r4_haddr3", haddr, 32'h2C);
      chk("r4_htrans3", 32'(htrans), 32'h3);
      chk("r4_rdata1", rdata, 32'hA0A0_0001);
      hrdata = 32'hA0A0_0002;
      tick();
      chk("r4_last_htrans", 32'(htrans), 32'h0);
      chk("r4_rdata2", rdata, 32'hA0A0_0002);
      hrdata = 32'hA0A0_0003;
      tick();
      chk("r4_rdata3", rdata, 32'hA0A0_0003);
      chk("r4_rv3", 32'(rdata_valid), 32'd1);
      chk("r4_done", 32'(done), 32'd1);
      tick();
      chk("r4_rv_count", 32'(rv_cnt - base), 32'd4);

      // WRAP4 write @0x38.
      base = pop_cnt;
      wdata = 32'hC0DE_0000;
      issue(1'b1, 32'h38, 3'b010, 8'd0);
      for (int i = 0; i < 4; i++) begin
         chk("w4_haddr", haddr, wrap_addr[i]);
         chk("w4_htrans", 32'(htrans), (i == 0) ? 32'h2 : 32'h3);
         chk("w4_hburst", 32'(hburst), 32'h2);
         if (i > 0) chk("w4_hwdata", hwdata, 32'hC0DE_0000 | 32'(i - 1));
         wdata = 32'hC0DE_0000 | 32'(i);
         tick();
      end
      chk("w4_last_hwdata", hwdata, 32'hC0DE_0003);
      chk("w4_last_hburst", 32'(hburst), 32'h2);
      tick();
      chk("w4_done", 32'(done), 32'd1);
      chk("w4_pops", 32'(pop_cnt - base), 32'd4);
      tick();

      // INCR len=3 read @0x3F8 crossing a 1KB page.
      issue(1'b0, 32'h3F8, 3'b001, 8'd3);
      for (int i = 0; i < 4; i++) begin
         chk("x_haddr", haddr, cross_addr[i]);
         chk("x_htrans", 32'(htrans), 32'(cross_tr[i]));
         chk("x_hburst", 32'(hburst), 32'h1);
         tick();
      end
      chk("x_last_htrans", 32'(htrans), 32'h0);
      tick();
      chk("x_done", 32'(done), 32'd1);
      tick();

      // INCR8 write @0x100 with a two-cycle stall on beat 3.
      base = pop_cnt;
      issue(1'b1, 32'h100, 3'b101, 8'd0);
      for (int i = 0; i < 8; i++) begin
         chk("i8_haddr", haddr, 32'h100 + 32'(4 * i));
         chk("i8_htrans", 32'(htrans), (i == 0) ? 32'h2 : 32'h3);
         if (i > 0) chk("i8_hwdata", hwdata, 32'hBEEF_0000 | 32'(i - 1));
         wdata = 32'hBEEF_0000 | 32'(i);
         if (i == 3) begin
            hready = 1'b0;
            #1;
            chk("i8_stall_pop", 32'(wdata_pop), 32'd0);
            for (int s = 0; s < 2; s++) begin
               tick();
               chk("i8_stall_haddr", haddr, 32'h10C);
               chk("i8_stall_htrans", 32'(htrans), 32'h3);
               chk("i8_stall_hwdata", hwdata, 32'hBEEF_0002);
               chk("i8_stall_pop", 32'(wdata_pop), 32'd0);
            end
            hready = 1'b1;
            #1;
            chk("i8_resume_pop", 32'(wdata_pop), 32'd1);
         end
         tick();
      end
      chk("i8_last_hwdata", hwdata, 32'hBEEF_0007);
      chk("i8_last_htrans", 32'(htrans), 32'h0);
      tick();
      chk("i8_done", 32'(done), 32'd1);
      chk("i8_pops", 32'(pop_cnt - base), 32'd8);
      tick();

      // INCR4 read @0x40 with ERROR on the second beat.
      base = rv_cnt;
      issue(1'b0, 32'h40, 3'b011, 8'd0);
      chk("e_haddr0", haddr, 32'h40);
      tick();
      chk("e_haddr1", haddr, 32'h44);
      hrdata = 32'hE0E0_0001;
      tick();
      chk("e_haddr2", haddr, 32'h48);
      chk("e_rdata0", rdata, 32'hE0E0_0001);
      hrdata = 32'hFFFF_FFFF;
      hready = 1'b0;
      hresp  = 1'b1;
      tick();
      chk("e_htrans_idle", 32'(htrans), 32'h0);
      chk("e_fsm_err", 32'(fsm_state), 32'd4);
      chk("e_no_done", 32'(done), 32'd0);
      chk("e_rv_off", 32'(rdata_valid), 32'd0);
      hready = 1'b1;
      tick();
      chk("e_done", 32'(done), 32'd1);
      chk("e_done_err", 32'(done_err), 32'd1);
      chk("e_rv_err_beat", 32'(rdata_valid), 32'd0);
      chk("e_ready", 32'(cmd_ready), 32'd1);
      hresp = 1'b0;
      tick();
      chk("e_rv_count", 32'(rv_cnt - base), 32'd1);
      chk("e_htrans_after", 32'(htrans), 32'h0);

      // INCR8 write @0x200 aborted by reset mid-burst.
      base = done_cnt;
      wdata = 32'h5555_AAAA;
      issue(1'b1, 32'h200, 3'b101, 8'd0);
      tick();
      tick();
      chk("a_haddr_mid", haddr, 32'h208);
      hresetn = 1'b0;
      #1;
      chk_reset_outputs("abort");
      tick();
      hresetn = 1'b1;
      tick();
      tick();
      tick();
      chk("a_no_done", 32'(done_cnt - base), 32'd0);
      chk("a_idle_htrans", 32'(htrans), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
